// File: rtl/lsu_tlb_rtn_pkg.sv
// Shared types and sizing for the TLB diagnostic-read return buffer.
package lsu_tlb_rtn_pkg;

    // One return slot per hardware thread. The round-robin arbiter relies on
    // natural TID_W-bit wrap, so THREADS must be a power of two.
    localparam int THREADS = 4;
    localparam int TID_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } rtn_state_t;

    typedef struct packed {
        logic        valid;
        logic        perr;
        logic [63:0] data;
    } slot_t;

endpackage

// File: rtl/lsu_tlb_rd_rtn_if.sv
// Return handshake from the TLB read buffer to the load-return path.
interface lsu_tlb_rd_rtn_if;
    import lsu_tlb_rtn_pkg::*;

    logic             rtn_req;
    logic [TID_W-1:0] rtn_tid;
    logic [63:0]      rtn_data;
    logic             rtn_perr;
    logic             rtn_gnt;

    // The buffer drives the entry and receives the accept.
    modport master (
        output rtn_req,
        output rtn_tid,
        output rtn_data,
        output rtn_perr,
        input  rtn_gnt
    );

    // The load-return path observes the entry and drives the accept.
    modport slave (
        input  rtn_req,
        input  rtn_tid,
        input  rtn_data,
        input  rtn_perr,
        output rtn_gnt
    );

endinterface

// File: rtl/lsu_tlb_rtn_rrarb.sv
// Combinational round-robin arbiter: search starts one past rr_ptr and wraps.
module lsu_tlb_rtn_rrarb
    import lsu_tlb_rtn_pkg::*;
(
    input  logic [THREADS-1:0] req,
    input  logic [TID_W-1:0]   rr_ptr,
    output logic [THREADS-1:0] gnt,
    output logic [TID_W-1:0]   gnt_tid,
    output logic               gnt_vld
);

    logic [TID_W-1:0] idx;

    // Walk the requesters starting after the last winner; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_tid = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 1; i <= THREADS; i++) begin
            idx = rr_ptr + TID_W'(i);
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_tid  = idx;
            end
        end
    end

endmodule

// File: rtl/lsu_tlb_rd_rtn.sv
// Per-thread return buffer for ASI TLB diagnostic reads with a sticky parity log.
module lsu_tlb_rd_rtn
    import lsu_tlb_rtn_pkg::*;
(
    input  logic               rclk,
    input  logic               arst_l,
    input  logic               tlb_rd_vld_g,
    input  logic [TID_W-1:0]   tlb_rd_tid_g,
    input  logic               tlb_rd_is_data_g,
    input  logic [63:0]        lsu_tlb_rd_data,
    input  logic               tte_data_parity_error,
    input  logic               tte_tag_parity_error,
    input  logic               flush_vld,
    input  logic [TID_W-1:0]   flush_tid,
    input  logic               err_log_clr,
    lsu_tlb_rd_rtn_if.master   rtn,
    output logic [THREADS-1:0] thread_busy,
    output logic               ovf_err,
    output logic               err_log_vld,
    output logic [TID_W-1:0]   err_log_tid,
    output logic               err_log_is_data
);

    slot_t            slot_q [THREADS];
    rtn_state_t       state_q;
    logic [TID_W-1:0] rr_ptr_q;
    logic             rtn_req_q;
    logic [TID_W-1:0] rtn_tid_q;
    logic [63:0]      rtn_data_q;
    logic             rtn_perr_q;

    logic [THREADS-1:0] slot_vld;
    logic [THREADS-1:0] flush_mask;
    logic [THREADS-1:0] arb_req;
    logic [THREADS-1:0] arb_gnt;
    logic [TID_W-1:0]   arb_tid;
    logic               arb_vld;

    logic cap_perr;
    logic cap_busy;
    logic cap_flushed;
    logic cap_ok;
    logic cap_ovf;
    logic do_load;

    // A thread is busy while its slot holds an entry or it owns the output register.
    always_comb begin
        slot_vld    = '0;
        thread_busy = '0;
        for (int t = 0; t < THREADS; t++) begin
            slot_vld[t]    = slot_q[t].valid;
            thread_busy[t] = slot_q[t].valid | (rtn_req_q && (rtn_tid_q == TID_W'(t)));
        end
    end

    // Decode the flush target so a flushed slot is neither loaded nor captured this cycle.
    always_comb begin
        flush_mask = '0;
        if (flush_vld) begin
            flush_mask[flush_tid] = 1'b1;
        end
    end

    assign cap_perr    = tlb_rd_is_data_g ? tte_data_parity_error : tte_tag_parity_error;
    assign cap_busy    = thread_busy[tlb_rd_tid_g];
    assign cap_flushed = flush_vld && (flush_tid == tlb_rd_tid_g);
    assign cap_ok      = tlb_rd_vld_g && !cap_busy && !cap_flushed;
    assign cap_ovf     = tlb_rd_vld_g && cap_busy && !cap_flushed;

    assign arb_req = slot_vld & ~flush_mask;
    assign do_load = arb_vld && ((state_q == IDLE) || rtn.rtn_gnt);

    lsu_tlb_rtn_rrarb u_rrarb (
        .req     (arb_req),
        .rr_ptr  (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_tid (arb_tid),
        .gnt_vld (arb_vld)
    );

    // Slot storage: capture into a free slot, clear on flush or when moved to the output.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int t = 0; t < THREADS; t++) begin
                slot_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < THREADS; t++) begin
                if (cap_ok && (tlb_rd_tid_g == TID_W'(t))) begin
                    slot_q[t] <= '{valid: 1'b1, perr: cap_perr, data: lsu_tlb_rd_data};
                end else if (flush_mask[t] || (do_load && arb_gnt[t])) begin
                    slot_q[t].valid <= 1'b0;
                end
            end
        end
    end

    // Return FSM with registered outputs; a grant may reload the next winner in the same cycle.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q    <= IDLE;
            rr_ptr_q   <= TID_W'(THREADS - 1);
            rtn_req_q  <= 1'b0;
            rtn_tid_q  <= '0;
            rtn_data_q <= '0;
            rtn_perr_q <= 1'b0;
        end else begin
            if (do_load) begin
                state_q    <= REQ;
                rr_ptr_q   <= arb_tid;
                rtn_req_q  <= 1'b1;
                rtn_tid_q  <= arb_tid;
                rtn_data_q <= slot_q[arb_tid].data;
                rtn_perr_q <= slot_q[arb_tid].perr;
            end else if ((state_q == REQ) && rtn.rtn_gnt) begin
                state_q   <= IDLE;
                rtn_req_q <= 1'b0;
            end
        end
    end

    // Dropped-capture pulse, registered so it never depends combinationally on the capture.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            ovf_err <= 1'b0;
        end else begin
            ovf_err <= cap_ovf;
        end
    end

    // Sticky first-error log; a clear coinciding with a new error keeps the new one.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            err_log_vld     <= 1'b0;
            err_log_tid     <= '0;
            err_log_is_data <= 1'b0;
        end else if (cap_ok && cap_perr && (!err_log_vld || err_log_clr)) begin
            err_log_vld     <= 1'b1;
            err_log_tid     <= tlb_rd_tid_g;
            err_log_is_data <= tlb_rd_is_data_g;
        end else if (err_log_clr) begin
            err_log_vld     <= 1'b0;
            err_log_tid     <= '0;
            err_log_is_data <= 1'b0;
        end
    end

    assign rtn.rtn_req  = rtn_req_q;
    assign rtn.rtn_tid  = rtn_tid_q;
    assign rtn.rtn_data = rtn_data_q;
    assign rtn.rtn_perr = rtn_perr_q;

endmodule

// File: tb/tb_lsu_tlb_rd_rtn.sv
// Directed self-checking bench for the TLB diagnostic-read return buffer.
module tb_lsu_tlb_rd_rtn;
    import lsu_tlb_rtn_pkg::*;

    logic               rclk;
    logic               arst_l;
    logic               tlb_rd_vld_g;
    logic [TID_W-1:0]   tlb_rd_tid_g;
    logic               tlb_rd_is_data_g;
    logic [63:0]        lsu_tlb_rd_data;
    logic               tte_data_parity_error;
    logic               tte_tag_parity_error;
    logic               flush_vld;
    logic [TID_W-1:0]   flush_tid;
    logic               err_log_clr;
    logic [THREADS-1:0] thread_busy;
    logic               ovf_err;
    logic               err_log_vld;
    logic [TID_W-1:0]   err_log_tid;
    logic               err_log_is_data;

    int total = 0;
    int bad   = 0;

    lsu_tlb_rd_rtn_if rif ();

    lsu_tlb_rd_rtn dut (
        .rclk                  (rclk),
        .arst_l                (arst_l),
        .tlb_rd_vld_g          (tlb_rd_vld_g),
        .tlb_rd_tid_g          (tlb_rd_tid_g),
        .tlb_rd_is_data_g      (tlb_rd_is_data_g),
        .lsu_tlb_rd_data       (lsu_tlb_rd_data),
        .tte_data_parity_error (tte_data_parity_error),
        .tte_tag_parity_error  (tte_tag_parity_error),
        .flush_vld             (flush_vld),
        .flush_tid             (flush_tid),
        .err_log_clr           (err_log_clr),
        .rtn                   (rif),
        .thread_busy           (thread_busy),
        .ovf_err               (ovf_err),
        .err_log_vld           (err_log_vld),
        .err_log_tid           (err_log_tid),
        .err_log_is_data       (err_log_is_data)
    );

    // Free-running clock: rising edges at 5, 15, 25, ...
    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [TID_W-1:0] tid, input logic is_data,
                                 input logic [63:0] data, input logic dperr, input logic tperr,
                                 input logic fvld, input logic [TID_W-1:0] ftid, input logic clr);
        tlb_rd_vld_g          = vld;
        tlb_rd_tid_g          = tid;
        tlb_rd_is_data_g      = is_data;
        lsu_tlb_rd_data       = data;
        tte_data_parity_error = dperr;
        tte_tag_parity_error  = tperr;
        flush_vld             = fvld;
        flush_tid             = ftid;
        err_log_clr           = clr;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 2'd0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge rclk);
            @(negedge rclk);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        idleInputs();
        rif.rtn_gnt = 1'b0;
        arst_l = 1'b1;
        #1 arst_l = 1'b0;
        #1;
        checkOutput("rst_req",      64'(rif.rtn_req),   64'h0);
        checkOutput("rst_tid",      64'(rif.rtn_tid),   64'h0);
        checkOutput("rst_data",     rif.rtn_data,       64'h0);
        checkOutput("rst_perr",     64'(rif.rtn_perr),  64'h0);
        checkOutput("rst_busy",     64'(thread_busy),   64'h0);
        checkOutput("rst_ovf",      64'(ovf_err),       64'h0);
        checkOutput("rst_log_vld",  64'(err_log_vld),   64'h0);
        checkOutput("rst_log_tid",  64'(err_log_tid),   64'h0);
        checkOutput("rst_log_data", 64'(err_log_is_data), 64'h0);
        @(negedge rclk);
        arst_l = 1'b1;
        cycle(1);

        // Single read of tid 2 with a stalled grant.
        applyStimulus(1'b1, 2'd2, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1);
        idleInputs();
        checkOutput("t1_req_early", 64'(rif.rtn_req), 64'h0);
        checkOutput("t1_busy_slot", 64'(thread_busy), 64'h4);
        cycle(1);
        checkOutput("t1_req",  64'(rif.rtn_req),  64'h1);
        checkOutput("t1_tid",  64'(rif.rtn_tid),  64'h2);
        checkOutput("t1_data", rif.rtn_data,      64'hDEAD_BEEF_0123_4567);
        checkOutput("t1_perr", 64'(rif.rtn_perr), 64'h0);
        checkOutput("t1_busy_out", 64'(thread_busy), 64'h4);
        for (int k = 0; k < 3; k++) begin
            cycle(1);
            checkOutput("t1_hold_req",  64'(rif.rtn_req), 64'h1);
            checkOutput("t1_hold_tid",  64'(rif.rtn_tid), 64'h2);
            checkOutput("t1_hold_data", rif.rtn_data,     64'hDEAD_BEEF_0123_4567);
        end
        rif.rtn_gnt = 1'b1;
        cycle(1);
        rif.rtn_gnt = 1'b0;
        checkOutput("t1_req_drop",   64'(rif.rtn_req), 64'h0);
        checkOutput("t1_busy_clear", 64'(thread_busy), 64'h0);
        checkOutput("t1_no_ovf",     64'(ovf_err),     64'h0);

        // Round robin with the grant held: tids 0, 1, 3 return back to back.
        rif.rtn_gnt = 1'b1;
        applyStimulus(1'b1, 2'd0, 1'b0, 64'h0000_0000_0000_A0A0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1);
        applyStimulus(1'b1, 2'd1, 1'b0, 64'h1111_0000_0000_B1B1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1);
        checkOutput("t2_r0_req",  64'(rif.rtn_req), 64'h1);
        checkOutput("t2_r0_tid",  64'(rif.rtn_tid), 64'h0);
        checkOutput("t2_r0_data", rif.rtn_data,     64'h0000_0000_0000_A0A0);
        applyStimulus(1'b1, 2'd3, 1'b0, 64'h3333_0000_0000_C3C3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1);
        idleInputs();
        checkOutput("t2_r1_req",  64'(rif.rtn_req), 64'h1);
        checkOutput("t2_r1_tid",  64'(rif.rtn_tid), 64'h1);
        checkOutput("t2_r1_data", rif.rtn_data,     64'h1111_0000_0000_B1B1);
        cycle(1);
        checkOutput("t2_r3_req",  64'(rif.rtn_req), 64'h1);
        checkOutput("t2_r3_tid",  64'(rif.rtn_tid), 64'h3);
        checkOutput("t2_r3_data", rif.rtn_data,     64'h3333_0000_0000_C3C3);
        cycle(1);
        checkOutput("t2_idle", 64'(rif.rtn_req), 64'h0);
        rif.rtn_gnt = 1'b0;

        // Overflow: second capture to tid 1 is dropped and pulses ovf_err once.
        applyStimulus(1'b1, 2'd1, 1'b0, 64'hAAAA_0000_1111_2222, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1);
        applyStimulus(1'b1, 2'd1, 1'b0, 64'hBBBB_0000_3333_4444, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("t3_ovf_before", 64'(ovf_err), 64'h0);
        cycle(1);
        idleInputs();
        checkOutput("t3_ovf_pulse", 64'(ovf_err),     64'h1);
        checkOutput("t3_req",       64'(rif.rtn_req), 64'h1);
        checkOutput("t3_data",      rif.rtn_data,     64'hAAAA_0000_1111_2222);
        cycle(1);
        checkOutput("t3_ovf_end",  64'(ovf_err),     64'h0);
        checkOutput("t3_data_hold", rif.rtn_data,    64'hAAAA_0000_1111_2222);
        rif.rtn_gnt = 1'b1;
        cycle(1);
        rif.rtn_gnt = 1'b0;
        checkOutput("t3_req_drop", 64'(rif.rtn_req), 64'h0);
        checkOutput("t3_busy",     64'(thread_busy), 64'h0);

        // Flush race: pending tid 3 behind tid 0 is flushed and never returns.
        applyStimulus(1'b1, 2'd0, 1'b0, 64'h0C0C_0C0C_0C0C_0C0C, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1);
        applyStimulus(1'b1, 2'd3, 1'b0, 64'h0D0D_0D0D_0D0D_0D0D, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1);
        applyStimulus(1'b0, 2'd0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        checkOutput("t4_busy_pend", 64'(thread_busy), 64'h9);
        checkOutput("t4_tid0",      64'(rif.rtn_tid), 64'h0);
        cycle(1);
        idleInputs();
        checkOutput("t4_busy_flushed", 64'(thread_busy), 64'h1);
        rif.rtn_gnt = 1'b1;
        cycle(1);
        rif.rtn_gnt = 1'b0;
        checkOutput("t4_req_drop", 64'(rif.rtn_req), 64'h0);
        cycle(2);
        checkOutput("t4_no_rtn",  64'(rif.rtn_req), 64'h0);
        checkOutput("t4_busy_0",  64'(thread_busy), 64'h0);
        // Capture and flush of tid 0 together: no entry and no overflow.
        applyStimulus(1'b1, 2'd0, 1'b0, 64'h0E0E_0E0E_0E0E_0E0E, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        cycle(1);
        idleInputs();
        checkOutput("t4_race_ovf",  64'(ovf_err),     64'h0);
        checkOutput("t4_race_busy", 64'(thread_busy), 64'h0);
        cycle(1);
        checkOutput("t4_race_req",  64'(rif.rtn_req), 64'h0);

        // Error log: first error wins, clear plus new error logs the new one.
        applyStimulus(1'b1, 2'd1, 1'b1, 64'h5151_5151_5151_5151, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1);
        applyStimulus(1'b1, 2'd2, 1'b0, 64'h5252_5252_5252_5252, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        checkOutput("t5_log_vld",  64'(err_log_vld),     64'h1);
        checkOutput("t5_log_tid",  64'(err_log_tid),     64'h1);
        checkOutput("t5_log_data", 64'(err_log_is_data), 64'h1);
        cycle(1);
        checkOutput("t5_keep_tid",  64'(err_log_tid),     64'h1);
        checkOutput("t5_keep_data", 64'(err_log_is_data), 64'h1);
        checkOutput("t5_rtn_tid",   64'(rif.rtn_tid),     64'h1);
        checkOutput("t5_rtn_perr",  64'(rif.rtn_perr),    64'h1);
        applyStimulus(1'b1, 2'd3, 1'b0, 64'h5353_5353_5353_5353, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
        cycle(1);
        idleInputs();
        checkOutput("t5_clr_vld",  64'(err_log_vld),     64'h1);
        checkOutput("t5_clr_tid",  64'(err_log_tid),     64'h3);
        checkOutput("t5_clr_data", 64'(err_log_is_data), 64'h0);
        rif.rtn_gnt = 1'b1;
        cycle(1);
        checkOutput("t5_d2_tid",  64'(rif.rtn_tid),  64'h2);
        checkOutput("t5_d2_perr", 64'(rif.rtn_perr), 64'h1);
        cycle(1);
        checkOutput("t5_d3_tid",  64'(rif.rtn_tid),  64'h3);
        checkOutput("t5_d3_data", rif.rtn_data,      64'h5353_5353_5353_5353);
        cycle(1);
        rif.rtn_gnt = 1'b0;
        checkOutput("t5_drained", 64'(rif.rtn_req), 64'h0);

        // Reset while a return is outstanding and another entry is pending.
        applyStimulus(1'b1, 2'd2, 1'b0, 64'h6262_6262_6262_6262, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1);
        applyStimulus(1'b1, 2'd0, 1'b0, 64'h6060_6060_6060_6060, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1);
        idleInputs();
        checkOutput("t6_req", 64'(rif.rtn_req), 64'h1);
        checkOutput("t6_tid", 64'(rif.rtn_tid), 64'h2);
        #2 arst_l = 1'b0;
        #1;
        checkOutput("t6_rst_req",     64'(rif.rtn_req),   64'h0);
        checkOutput("t6_rst_tid",     64'(rif.rtn_tid),   64'h0);
        checkOutput("t6_rst_data",    rif.rtn_data,       64'h0);
        checkOutput("t6_rst_busy",    64'(thread_busy),   64'h0);
        checkOutput("t6_rst_log_vld", 64'(err_log_vld),   64'h0);
        checkOutput("t6_rst_log_tid", 64'(err_log_tid),   64'h0);
        @(negedge rclk);
        arst_l = 1'b1;
        cycle(1);
        checkOutput("t6_post_req",  64'(rif.rtn_req), 64'h0);
        checkOutput("t6_post_busy", 64'(thread_busy), 64'h0);
        cycle(2);
        checkOutput("t6_post_req2", 64'(rif.rtn_req), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
